// File: rtl/serial_feeder.sv
// Parallel-to-serial feeder: accepts one MSB-bit word when idle and streams it
// one bit per cycle, LSB- or MSB-first, to a downstream shift register.
module serial_feeder #(
    parameter int MSB = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [MSB-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           lsb_first,
    output logic           d,
    output logic           en,
    output logic           dir,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(MSB + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CW-1:0] LAST_IDX = CW'(MSB - 1);

    logic [1:0]     r_state;
    logic [CW-1:0]  r_cnt;
    logic [MSB-1:0] r_shift;
    logic           r_d;
    logic           r_en;
    logic           r_dir;
    logic           r_done;

    // The outgoing bit is always taken from the end the frame order points at.
    function automatic logic head_bit(input logic [MSB-1:0] data, input logic lsb);
        head_bit = lsb ? data[0] : data[MSB-1];
    endfunction

    function automatic logic [MSB-1:0] advance(input logic [MSB-1:0] data, input logic lsb);
        advance = lsb ? {1'b0, data[MSB-1:1]} : {data[MSB-2:0], 1'b0};
    endfunction

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign d        = r_d;
    assign en       = r_en;
    assign dir      = r_dir;
    assign done     = r_done;

    // Frame sequencing: capture on accept, stream MSB bits, one DONE cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_d     <= 1'b0;
            r_en    <= 1'b0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (in_valid) begin
                        r_d     <= head_bit(in_data, lsb_first);
                        r_shift <= advance(in_data, lsb_first);
                        r_dir   <= lsb_first;
                        r_en    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end else begin
                        r_d  <= 1'b0;
                        r_en <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_IDX) begin
                        r_d     <= 1'b0;
                        r_en    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_d     <= head_bit(r_shift, r_dir);
                        r_shift <= advance(r_shift, r_dir);
                    end
                end
                DONE: begin
                    r_d     <= 1'b0;
                    r_en    <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_d     <= 1'b0;
                    r_en    <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_feeder.sv
// Randomized scoreboard bench for serial_feeder: accepts are predicted from
// the handshake rules and expand into time-stamped expected bits and done pulses.
module tb_serial_feeder;

    localparam int MSB = 4;

    logic           clk = 1'b0;
    logic           rstn;
    logic [MSB-1:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic           lsb_first;
    logic           d;
    logic           en;
    logic           dir;
    logic           busy;
    logic           done;

    serial_feeder #(.MSB(MSB)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lsb_first (lsb_first),
        .d         (d),
        .en        (en),
        .dir       (dir),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic b;
    } exp_bit_t;

    exp_bit_t bit_q[$];
    int       done_q[$];
    logic     stream_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accept_cnt = 0;
    int   done_cnt = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    logic exp_dir = 1'b0;
    bit   armed = 1'b0;

    task automatic chk(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare this cycle's outputs, then predict the effect of the coming edge.
    always @(negedge clk) begin
        logic exp_busy;
        exp_bit_t e;
        exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        if (armed) begin
            while (bit_q.size() > 0 && bit_q[0].cyc < cyc) begin
                chk("missing_bit", 1'b0, 1'b1);
                void'(bit_q.pop_front());
            end
            if (en === 1'b1) begin
                stream_q.push_back(d);
                if (bit_q.size() > 0 && bit_q[0].cyc == cyc) begin
                    e = bit_q.pop_front();
                    chk("d_bit", d, e.b);
                end else begin
                    chk("unexpected_en", en, 1'b0);
                end
            end else begin
                chk("en_low", en, 1'b0);
                chk("d_idle", d, 1'b0);
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                chk("missing_done", 1'b0, 1'b1);
                void'(done_q.pop_front());
            end
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                void'(done_q.pop_front());
                chk("done_pulse", done, 1'b1);
            end else begin
                chk("done_low", done, 1'b0);
            end
            if (done === 1'b1) done_cnt++;
            chk("dir", dir, exp_dir);
            chk("busy", busy, exp_busy);
            chk("in_ready", in_ready, !exp_busy);
        end
        if (rstn !== 1'b1) begin
            bit_q.delete();
            done_q.delete();
            exp_dir = 1'b0;
            busy_lo = 1;
            busy_hi = 0;
            armed   = 1'b1;
        end else if (armed && in_valid && !exp_busy) begin
            accept_cnt++;
            exp_dir = lsb_first;
            busy_lo = cyc + 1;
            busy_hi = cyc + 1 + MSB;
            for (int i = 0; i < MSB; i++) begin
                e.cyc = cyc + 1 + i;
                e.b   = lsb_first ? in_data[i] : in_data[MSB-1-i];
                bit_q.push_back(e);
            end
            done_q.push_back(cyc + 1 + MSB);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_accepts(input int target);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (accept_cnt >= target) break;
        end
        if (k == 100) chk_int("accept_timeout", accept_cnt, target);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [MSB-1:0] data, input logic lsb, input bit scramble);
        in_data   = data;
        lsb_first = lsb;
        in_valid  = 1'b1;
        wait_accepts(accept_cnt + 1);
        in_valid = 1'b0;
        for (int i = 0; i <= MSB; i++) begin
            if (scramble) begin
                in_data   = MSB'($urandom);
                lsb_first = 1'($urandom);
                in_valid  = 1'($urandom);
            end
            step(1);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_stream(input logic [15:0] exp, input int n, input string nm);
        logic [15:0] ev;
        ev = exp;
        chk_int({nm, "_len"}, stream_q.size(), n);
        for (int i = 0; i < n && i < stream_q.size(); i++)
            chk(nm, stream_q[i], ev[n-1-i]);
    endtask

    initial begin
        int base;
        int mode;
        rstn      = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        lsb_first = 1'b0;
        step(2);
        rstn = 1'b1;
        step(2);

        stream_q.delete(); done_cnt = 0;
        send(4'b1011, 1'b1, 1'b0);
        step(1);
        check_stream(16'b1101, 4, "lsb_first_seq");
        chk_int("lsb_first_done", done_cnt, 1);

        stream_q.delete(); done_cnt = 0;
        send(4'b1011, 1'b0, 1'b0);
        step(1);
        check_stream(16'b1011, 4, "msb_first_seq");
        chk_int("msb_first_done", done_cnt, 1);

        stream_q.delete(); done_cnt = 0;
        base      = accept_cnt;
        in_data   = 4'b0110;
        lsb_first = 1'b1;
        in_valid  = 1'b1;
        wait_accepts(base + 1);
        in_data   = 4'b1001;
        lsb_first = 1'b0;
        wait_accepts(base + 2);
        in_valid = 1'b0;
        step(MSB + 2);
        check_stream(16'b01101001, 8, "b2b_seq");
        chk_int("b2b_done", done_cnt, 2);

        stream_q.delete(); done_cnt = 0;
        send_partial: begin
            in_data   = 4'b1111;
            lsb_first = 1'b1;
            in_valid  = 1'b1;
            wait_accepts(accept_cnt + 1);
            in_valid = 1'b0;
            step(1);
            rstn = 1'b0;
            step(1);
            rstn = 1'b1;
        end
        step(6);
        check_stream(16'b11, 2, "reset_mid_seq");
        chk_int("reset_mid_done", done_cnt, 0);
        stream_q.delete();
        send(4'b1100, 1'b1, 1'b0);
        step(1);
        check_stream(16'b0011, 4, "post_reset_seq");

        stream_q.delete();
        send(4'b0101, 1'b0, 1'b1);
        step(1);
        check_stream(16'b0101, 4, "stable_seq");

        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 4);
            if (mode == 0) begin
                base      = accept_cnt;
                in_data   = MSB'($urandom);
                lsb_first = 1'($urandom);
                in_valid  = 1'b1;
                wait_accepts(base + 1);
                in_data   = MSB'($urandom);
                lsb_first = 1'($urandom);
                wait_accepts(base + 2);
                in_valid = 1'b0;
            end else if (mode == 1) begin
                in_data   = MSB'($urandom);
                lsb_first = 1'($urandom);
                in_valid  = 1'b1;
                wait_accepts(accept_cnt + 1);
                in_valid = 1'b0;
                step($urandom_range(0, MSB + 1));
                rstn = 1'b0;
                step(1);
                rstn = 1'b1;
            end else begin
                send(MSB'($urandom), 1'($urandom), 1'($urandom));
            end
            step($urandom_range(0, 3));
        end

        step(MSB + 4);
        chk_int("bits_drained", bit_q.size(), 0);
        chk_int("dones_drained", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_feeder.md
SERIAL_FEEDER -- requirements
Module: serial_feeder

Interface
REQ-001 The block SHALL have parameter MSB, default 4, the parallel word width in bits; legal range is MSB >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: the reset, synchronous and active-low.
REQ-004 The block SHALL have port in_data, input, MSB bits: the parallel word to serialize.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 The block SHALL have port lsb_first, input, 1 bit: the bit order for the offered word; 1 means bit 0 first, 0 means bit MSB-1 first.
REQ-008 The block SHALL have port d, output, 1 bit: the serial data bit to the downstream shift register.
REQ-009 The block SHALL have port en, output, 1 bit: shift enable to downstream; d is valid when en=1.
REQ-010 The block SHALL have port dir, output, 1 bit: shift direction to downstream, equal to the captured lsb_first of the current frame.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last bit of a frame.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; it is decoded from the state register.
REQ-015 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; at that edge the block captures in_data and lsb_first, clears the bit counter and moves to SHIFT.
REQ-016 In SHIFT, on each cycle, the block SHALL present en=1 and one bit on d; the bit counter, $clog2(MSB+1) bits wide, increments each cycle.
REQ-017 d, en, dir and done SHALL be registered outputs with no combinational path from any input.
REQ-018 Cycle-level timing, for accept at edge k:
- d/en carry bit 0..MSB-1 of the chosen order during cycles k+1 .. k+MSB;
- done=1 and en=0 during cycle k+MSB+1 (state DONE);
- in_ready=1 from cycle k+MSB+2.
REQ-019 Bit order SHALL be: when lsb_first=1, in_data[0] first through in_data[MSB-1]; otherwise in_data[MSB-1] first through in_data[0].
REQ-020 dir SHALL hold the captured lsb_first value for the whole frame, including DONE, and keep that value in IDLE until the next accept.
REQ-021 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-022 In IDLE and DONE, the block SHALL drive en=0 and d=0.
REQ-023 Changes to in_data or lsb_first after accept SHALL NOT affect the frame in progress.
REQ-024 in_valid asserted in SHIFT or DONE SHALL be ignored; the block does not accept it and no word is lost from the source's view, since in_ready=0.
REQ-025 With in_valid held high continuously, frames SHALL run back-to-back with exactly 2 cycles of en=0 between the last bit of one frame and the first bit of the next.
REQ-026 The block SHALL support no abort; once accepted, a frame always completes unless reset.

Reset
REQ-027 When rstn=0 at a rising edge, the block SHALL move to IDLE and set d=0, en=0, dir=0, done=0, busy=0 and counter=0, so in_ready=1 on the next cycle.
REQ-028 Reset SHALL take priority over any accept or shift in the same cycle; a frame in progress is discarded and no done pulse is issued.
REQ-029 rstn SHALL NOT affect outputs asynchronously; between edges, outputs hold their values.

Verification (MSB=4)
REQ-030 Reset scenario: rstn=0 for 2 edges, then 1 -> d=0, en=0, dir=0, done=0, busy=0, in_ready=1.
REQ-031 LSB-first scenario: accept 4'b1011 with lsb_first=1 -> d sequence 1,1,0,1 with en=1 for 4 cycles and dir=1, then done=1 for one cycle, then in_ready=1.
REQ-032 MSB-first scenario: accept 4'b1011 with lsb_first=0 -> d sequence 1,0,1,1 with dir=0, then a single done pulse.
REQ-033 Back-to-back scenario: in_valid held high with 4'b0110 (lsb_first=1) then 4'b1001 (lsb_first=0) -> d sequence 0,1,1,0, then 2 idle cycles, then 1,0,0,1; exactly 2 done pulses.
REQ-034 Reset mid-frame scenario: rstn=0 after the 2nd bit -> all outputs reset at the next edge and no done pulse; a subsequent accept of 4'b1100 (lsb_first=1) streams 0,0,1,1.
REQ-035 Input-stability scenario: in_data and lsb_first toggled every cycle during SHIFT -> the streamed bits and dir match the values captured at accept.
